ulpi_phy_reg_responder: RTL and testbench

PHY-side ULPI responder for simulation and FPGA loopback. It answers register read and write TXCMDs issued by the ULPI link over DIR/NXT/STP and DATA. It holds a small PHY register file and emits RXCMD bytes when line state changes. It sits on the far end of the `USB_DATA`/`USB_DIR`/`USB_NXT`/`USB_STP` bus, replacing the physical PHY in link-layer benches.

---
 rtl/ulpi_pkg.sv | 49 ++++
 rtl/ulpi_phy_regfile.sv | 83 ++++++++
 rtl/ulpi_phy_reg_responder.sv | 141 ++++++++++++++
 tb/tb_ulpi_phy_reg_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared constants for the ULPI PHY register responder.
//   - register base addresses and set/clear alias offsets
//   - TXCMD opcode field values
//   - responder FSM state encoding
//   - register reset defaults and the alias-apply helper
package ulpi_pkg;

   localparam logic [5:0] ADDR_FUN_CTRL = 6'h04;
   localparam logic [5:0] ADDR_OTG_CTRL = 6'h0A;
   localparam logic [5:0] ADDR_SCRATCH  = 6'h16;
   localparam logic [5:0] OFS_SET       = 6'h01;
   localparam logic [5:0] OFS_CLR       = 6'h02;

   // TXCMD[7:6]
   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;

   localparam logic [7:0] FUN_CTRL_RST = 8'h41;
   localparam logic [7:0] OTG_CTRL_RST = 8'h06;
   localparam logic [7:0] SCRATCH_RST  = 8'h00;
   localparam int         FUN_RESET_BIT = 5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_CMD,
      ST_WR_DATA,
      ST_WR_STP,
      ST_RD_CMD,
      ST_RD_TURN,
      ST_RD_DATA,
      ST_RD_END,
      ST_RX_TURN,
      ST_RX_DATA,
      ST_RX_END
   } ulpi_state_e;

   // op: 0 = write, 1 = set (OR), 2 = clear (AND-NOT)
   function automatic logic [7:0] apply_alias(input logic [7:0] cur,
                                              input logic [7:0] wd,
                                              input logic [1:0] op);
      case (op)
         2'd0:    apply_alias = wd;
         2'd1:    apply_alias = cur | wd;
         2'd2:    apply_alias = cur & ~wd;
         default: apply_alias = cur;
      endcase
   endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// ulpi_phy_regfile: PHY register file with write/set/clear aliases.
//   clk_i, rst_ni     : clock, async active-low reset
//   addr_i            : register address of the current transaction
//   wdata_i           : write data
//   commit_i          : commit strobe (write lands on this edge)
//   wr_hit_o          : addr_i maps onto a writable register
//   rd_data_o         : combinational read data (ID bytes, registers, else 0)
//   fun_ctrl_o, otg_ctrl_o : register contents for observation
module ulpi_phy_regfile
   import ulpi_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID  = 16'h0424,
   parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [5:0] addr_i,
   input  logic [7:0] wdata_i,
   input  logic       commit_i,
   output logic       wr_hit_o,
   output logic [7:0] rd_data_o,
   output logic [7:0] fun_ctrl_o,
   output logic [7:0] otg_ctrl_o
);

   logic [7:0] fun_q, otg_q, scr_q;
   logic [7:0] fun_wr, otg_wr, scr_wr;
   logic [7:0] fun_rd, otg_rd, scr_rd;
   logic       hit_fun, hit_otg, hit_scr;
   logic [5:0] ofs_fun, ofs_otg, ofs_scr;

   assign ofs_fun = addr_i - ADDR_FUN_CTRL;
   assign ofs_otg = addr_i - ADDR_OTG_CTRL;
   assign ofs_scr = addr_i - ADDR_SCRATCH;

   assign hit_fun = (addr_i >= ADDR_FUN_CTRL) && (addr_i <= ADDR_FUN_CTRL + OFS_CLR);
   assign hit_otg = (addr_i >= ADDR_OTG_CTRL) && (addr_i <= ADDR_OTG_CTRL + OFS_CLR);
   assign hit_scr = (addr_i >= ADDR_SCRATCH)  && (addr_i <= ADDR_SCRATCH + OFS_CLR);
   assign wr_hit_o = hit_fun | hit_otg | hit_scr;

   assign fun_wr = hit_fun ? apply_alias(fun_q, wdata_i, ofs_fun[1:0]) : fun_q;
   assign otg_wr = hit_otg ? apply_alias(otg_q, wdata_i, ofs_otg[1:0]) : otg_q;
   assign scr_wr = hit_scr ? apply_alias(scr_q, wdata_i, ofs_scr[1:0]) : scr_q;

   // A read in the commit cycle sees the post-commit value.
   assign fun_rd = commit_i ? fun_wr : fun_q;
   assign otg_rd = commit_i ? otg_wr : otg_q;
   assign scr_rd = commit_i ? scr_wr : scr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fun_q <= FUN_CTRL_RST;
         otg_q <= OTG_CTRL_RST;
         scr_q <= SCRATCH_RST;
      end else begin
         // Reset bit is held for exactly one cycle after a commit that sets it.
         if (commit_i && hit_fun) fun_q <= fun_wr;
         else                     fun_q[FUN_RESET_BIT] <= 1'b0;
         if (commit_i && hit_otg) otg_q <= otg_wr;
         if (commit_i && hit_scr) scr_q <= scr_wr;
      end
   end

   always_comb begin
      rd_data_o = 8'h00;
      if (hit_fun)      rd_data_o = fun_rd;
      else if (hit_otg) rd_data_o = otg_rd;
      else if (hit_scr) rd_data_o = scr_rd;
      else begin
         case (addr_i)
            6'h00:   rd_data_o = VENDOR_ID[7:0];
            6'h01:   rd_data_o = VENDOR_ID[15:8];
            6'h02:   rd_data_o = PRODUCT_ID[7:0];
            6'h03:   rd_data_o = PRODUCT_ID[15:8];
            default: rd_data_o = 8'h00;
         endcase
      end
   end

   assign fun_ctrl_o = fun_q;
   assign otg_ctrl_o = otg_q;

endmodule

// File: rtl/ulpi_phy_reg_responder.sv
// ulpi_phy_reg_responder: PHY-side ULPI model answering register TXCMDs
// and sending RXCMDs on line-state change.
//   CLK_60M, NRST_A_USB   : ULPI clock, async active-low reset
//   DATA_I, STP           : link-driven bus value and stop
//   LINESTATE, VBUS_STATE : line model inputs reported in RXCMD
//   DATA_O, DATA_OE       : PHY-driven bus value and enable
//   DIR, NXT              : bus ownership and handshake
//   FUN_CTRL_O, OTG_CTRL_O: register contents
//   WR_STRB               : one-cycle pulse per committed write
//   ABORT_CNT             : saturating count of writes ended without STP
module ulpi_phy_reg_responder
   import ulpi_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID  = 16'h0424,
   parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
   input  logic       CLK_60M,
   input  logic       NRST_A_USB,
   input  logic [7:0] DATA_I,
   input  logic       STP,
   input  logic [1:0] LINESTATE,
   input  logic [1:0] VBUS_STATE,
   output logic [7:0] DATA_O,
   output logic       DATA_OE,
   output logic       DIR,
   output logic       NXT,
   output logic [7:0] FUN_CTRL_O,
   output logic [7:0] OTG_CTRL_O,
   output logic       WR_STRB,
   output logic [7:0] ABORT_CNT
);

   ulpi_state_e state_q;
   logic [5:0]  addr_q;
   logic [7:0]  wdata_q;
   logic        nxt_q, dir_q, oe_q, wr_strb_q;
   logic [7:0]  dout_q, abort_q;
   logic [3:0]  line_q, rx_val_q;
   logic [3:0]  line_d;
   logic        rx_pend_q;
   logic        line_chg, commit, wr_hit;
   logic [7:0]  rd_data;

   assign line_d   = {VBUS_STATE, LINESTATE};
   assign line_chg = (line_d != line_q);
   assign commit   = (state_q == ST_WR_STP) && STP;

   ulpi_phy_regfile #(
      .VENDOR_ID  (VENDOR_ID),
      .PRODUCT_ID (PRODUCT_ID)
   ) u_regfile (
      .clk_i      (CLK_60M),
      .rst_ni     (NRST_A_USB),
      .addr_i     (addr_q),
      .wdata_i    (wdata_q),
      .commit_i   (commit),
      .wr_hit_o   (wr_hit),
      .rd_data_o  (rd_data),
      .fun_ctrl_o (FUN_CTRL_O),
      .otg_ctrl_o (OTG_CTRL_O)
   );

   always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
      if (!NRST_A_USB) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         nxt_q     <= 1'b0;
         dir_q     <= 1'b0;
         oe_q      <= 1'b0;
         dout_q    <= '0;
         wr_strb_q <= 1'b0;
         abort_q   <= '0;
         line_q    <= '0;
         rx_val_q  <= '0;
         rx_pend_q <= 1'b0;
      end else begin
         wr_strb_q <= 1'b0;
         line_q    <= line_d;
         if (line_chg) rx_val_q <= line_d;
         // A change seen while the RXCMD is going out re-arms rx_pend.
         if (line_chg)                    rx_pend_q <= 1'b1;
         else if (state_q == ST_RX_TURN)  rx_pend_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (DATA_I[7]) begin
                  addr_q  <= DATA_I[5:0];
                  nxt_q   <= 1'b1;
                  state_q <= (DATA_I[7:6] == TXCMD_REGR) ? ST_RD_CMD : ST_WR_CMD;
               end else if (rx_pend_q) begin
                  dir_q   <= 1'b1;
                  state_q <= ST_RX_TURN;
               end
            end
            ST_WR_CMD:  state_q <= ST_WR_DATA;
            ST_WR_DATA: begin
               wdata_q <= DATA_I;
               nxt_q   <= 1'b0;
               state_q <= ST_WR_STP;
            end
            ST_WR_STP: begin
               if (STP)                  wr_strb_q <= wr_hit;
               else if (abort_q != 8'hFF) abort_q  <= abort_q + 8'd1;
               state_q <= ST_IDLE;
            end
            ST_RD_CMD: begin
               nxt_q   <= 1'b0;
               dir_q   <= 1'b1;
               state_q <= ST_RD_TURN;
            end
            ST_RD_TURN: begin
               oe_q    <= 1'b1;
               dout_q  <= rd_data;
               state_q <= ST_RD_DATA;
            end
            ST_RX_TURN: begin
               oe_q    <= 1'b1;
               dout_q  <= {4'b0000, rx_val_q};
               state_q <= ST_RX_DATA;
            end
            ST_RD_DATA, ST_RX_DATA: begin
               dir_q   <= 1'b0;
               oe_q    <= 1'b0;
               dout_q  <= 8'h00;
               state_q <= (state_q == ST_RD_DATA) ? ST_RD_END : ST_RX_END;
            end
            ST_RD_END, ST_RX_END: state_q <= ST_IDLE;
            default:              state_q <= ST_IDLE;
         endcase
      end
   end

   assign DATA_O    = dout_q;
   assign DATA_OE   = oe_q;
   assign DIR       = dir_q;
   assign NXT       = nxt_q;
   assign WR_STRB   = wr_strb_q;
   assign ABORT_CNT = abort_q;

endmodule

// File: tb/tb_ulpi_phy_reg_responder.sv
// Bench for ulpi_phy_reg_responder: link-side driver tasks plus a bus
// monitor that pops expected PHY-driven bytes from a scoreboard queue.
module tb_ulpi_phy_reg_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       stp = 1'b0;
   logic [1:0] ls = 2'b00, vbus = 2'b00;
   logic [7:0] data_o, fun_ctrl, otg_ctrl, abort_cnt;
   logic       data_oe, dir, nxt, wr_strb;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic       prev_oe = 1'b0;

   ulpi_phy_reg_responder dut (
      .CLK_60M    (clk),
      .NRST_A_USB (rst_n),
      .DATA_I     (data_i),
      .STP        (stp),
      .LINESTATE  (ls),
      .VBUS_STATE (vbus),
      .DATA_O     (data_o),
      .DATA_OE    (data_oe),
      .DIR        (dir),
      .NXT        (nxt),
      .FUN_CTRL_O (fun_ctrl),
      .OTG_CTRL_O (otg_ctrl),
      .WR_STRB    (wr_strb),
      .ABORT_CNT  (abort_cnt)
   );

   always #8 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Scoreboard side: every PHY-driven byte must match the next expected one,
   // with DIR high and DATA_OE lasting a single cycle.
   always @(negedge clk) begin
      if (rst_n && data_oe) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL bus_unexpected got=%02h exp=none", data_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (data_o !== mon_exp || dir !== 1'b1) begin
               bad++;
               $display("FAIL bus_byte got=%02h/dir%b exp=%02h/dir1", data_o, dir, mon_exp);
            end
         end
         total++;
         if (prev_oe) begin
            bad++;
            $display("FAIL oe_width got=2+ cycles exp=1");
         end
      end
      prev_oe <= data_oe;
   end

   task automatic send_cmd(input logic [7:0] cmd, input string nm, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      data_i = cmd;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (nxt === 1'b1) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s_nxt got=0 exp=1", nm);
         data_i = 8'h00;
      end
   endtask

   task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic s,
                           input logic exp_strb, input string nm);
      bit ok;
      send_cmd({2'b10, a}, nm, ok);
      if (!ok) return;
      data_i = d;
      @(posedge clk); #1;
      total++;
      if (nxt !== 1'b1) begin bad++; $display("FAIL %s_nxt_k1 got=%b exp=1", nm, nxt); end
      @(posedge clk); #1;
      total++;
      if (nxt !== 1'b0) begin bad++; $display("FAIL %s_nxt_k2 got=%b exp=0", nm, nxt); end
      data_i = 8'h00;
      stp = s;
      @(posedge clk); #1;
      stp = 1'b0;
      total++;
      if (wr_strb !== exp_strb) begin
         bad++; $display("FAIL %s_strb got=%b exp=%b", nm, wr_strb, exp_strb);
      end
   endtask

   task automatic do_read(input logic [5:0] a, input logic [7:0] e, input string nm);
      bit ok;
      send_cmd({2'b11, a}, nm, ok);
      if (!ok) return;
      exp_q.push_back(e);
      data_i = 8'h00;
      @(posedge clk); #1;
      total++;
      if (dir !== 1'b1 || nxt !== 1'b0 || data_oe !== 1'b0) begin
         bad++; $display("FAIL %s_turn got=dir%b nxt%b oe%b exp=dir1 nxt0 oe0", nm, dir, nxt, data_oe);
      end
      @(posedge clk);
      @(posedge clk); #1;
      total++;
      if (dir !== 1'b0 || data_oe !== 1'b0) begin
         bad++; $display("FAIL %s_release got=dir%b oe%b exp=dir0 oe0", nm, dir, data_oe);
      end
      @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string nm);
      total++;
      if (dir !== 1'b0 || nxt !== 1'b0 || data_oe !== 1'b0 || data_o !== 8'h00 ||
          wr_strb !== 1'b0 || abort_cnt !== 8'h00) begin
         bad++;
         $display("FAIL %s_outs got=dir%b nxt%b oe%b do%02h strb%b ab%02h exp=all zero",
                  nm, dir, nxt, data_oe, data_o, wr_strb, abort_cnt);
      end
      total++;
      if (fun_ctrl !== 8'h41 || otg_ctrl !== 8'h06) begin
         bad++; $display("FAIL %s_regs got=%02h/%02h exp=41/06", nm, fun_ctrl, otg_ctrl);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_write_read();
      do_write(6'h16, 8'hA5, 1'b1, 1'b1, "wr_scr");
      @(posedge clk); #1;
      total++;
      if (wr_strb !== 1'b0) begin bad++; $display("FAIL wr_scr_strb_pulse got=%b exp=0", wr_strb); end
      do_read(6'h16, 8'hA5, "rd_scr");
   endtask

   task automatic test_set_clear();
      do_write(6'h05, 8'h04, 1'b1, 1'b1, "set_fun");
      total++;
      if (fun_ctrl !== 8'h45) begin bad++; $display("FAIL set_fun_val got=%02h exp=45", fun_ctrl); end
      do_read(6'h04, 8'h45, "rd_fun_set");
      do_write(6'h06, 8'h01, 1'b1, 1'b1, "clr_fun");
      total++;
      if (fun_ctrl !== 8'h44) begin bad++; $display("FAIL clr_fun_val got=%02h exp=44", fun_ctrl); end
      do_read(6'h04, 8'h44, "rd_fun_clr");
      // Reset bit self-clears one cycle after the commit
      do_write(6'h05, 8'h20, 1'b1, 1'b1, "set_rst");
      total++;
      if (fun_ctrl !== 8'h64) begin bad++; $display("FAIL set_rst_val got=%02h exp=64", fun_ctrl); end
      @(posedge clk); #1;
      total++;
      if (fun_ctrl !== 8'h44) begin bad++; $display("FAIL rst_selfclr got=%02h exp=44", fun_ctrl); end
   endtask

   task automatic test_abort();
      do_write(6'h0A, 8'h55, 1'b0, 1'b0, "abort");
      total++;
      if (otg_ctrl !== 8'h06 || abort_cnt !== 8'h01) begin
         bad++; $display("FAIL abort_state got=otg%02h cnt%02h exp=otg06 cnt01", otg_ctrl, abort_cnt);
      end
   endtask

   task automatic test_rxcmd();
      @(negedge clk);
      vbus = 2'b11;
      exp_q.push_back(8'h0C);
      repeat (8) @(posedge clk);
      @(negedge clk);
      ls = 2'b01;
      exp_q.push_back(8'h0D);
      @(posedge clk); #1;            // edge j: change registered
      total++;
      if (dir !== 1'b0) begin bad++; $display("FAIL rx_dir_j got=%b exp=0", dir); end
      @(posedge clk); #1;
      total++;
      if (dir !== 1'b1 || data_oe !== 1'b0) begin
         bad++; $display("FAIL rx_turn got=dir%b oe%b exp=dir1 oe0", dir, data_oe);
      end
      @(posedge clk);
      @(posedge clk); #1;
      total++;
      if (dir !== 1'b0) begin bad++; $display("FAIL rx_release got=%b exp=0", dir); end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_collision();
      @(negedge clk);
      ls = 2'b00;
      exp_q.push_back(8'h0C);
      repeat (8) @(posedge clk);
      // Read cmd and line change in the same cycle: read goes first
      @(negedge clk);
      ls = 2'b01;
      data_i = 8'hD6;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h0D);
      @(posedge clk); #1;
      data_i = 8'h00;
      total++;
      if (nxt !== 1'b1 || dir !== 1'b0) begin
         bad++; $display("FAIL coll_accept got=nxt%b dir%b exp=nxt1 dir0", nxt, dir);
      end
      repeat (12) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL coll_drain got=%0d pending exp=0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      send_cmd(8'h84, "rst_mid", ok);
      if (ok) begin
         data_i = 8'h00;
         @(posedge clk); #1;         // now in WR_DATA
         rst_n = 1'b0;
         #1;
         check_reset_outputs("rst_mid");
      end
      @(negedge clk);
      // Line inputs (VBUS=11, LS=01) differ from the cleared copy
      exp_q.push_back(8'h0D);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      do_read(6'h00, 8'h24, "rd_id0");
      do_read(6'h01, 8'h04, "rd_id1");
      do_read(6'h02, 8'h09, "rd_id2");
      do_read(6'h3F, 8'h00, "rd_unmapped");
      do_read(6'h16, 8'h00, "rd_scr_rst");
      do_read(6'h04, 8'h41, "rd_fun_rst");
   endtask

   task automatic test_back_to_back();
      do_write(6'h16, 8'h3C, 1'b1, 1'b1, "b2b_w1");
      do_write(6'h17, 8'h81, 1'b1, 1'b1, "b2b_w2");
      do_read(6'h16, 8'hBD, "b2b_rd");
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL final_drain got=%0d pending exp=0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_set_clear();
      test_abort();
      test_rxcmd();
      test_collision();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
